// File: rtl/dff_arb_pkg.sv
// rtl/dff_arb_pkg.sv - shared constants and FSM state encoding for the write arbiter
package dff_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/dff_write_arbiter_if.sv
// rtl/dff_write_arbiter_if.sv - requester/arbiter bus bundle for the shared write register
interface dff_write_arbiter_if
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       Q;
  logic [IDX_W-1:0]       owner;
  logic                   q_valid;
  logic [CNT_W-1:0]       commit_cnt;

  modport master (
    output req, wdata,
    input  gnt, ack, Q, owner, q_valid, commit_cnt
  );

  modport slave (
    input  req, wdata,
    output gnt, ack, Q, owner, q_valid, commit_cnt
  );

endinterface

// File: rtl/dff_write_arbiter_rr_pick.sv
// rtl/dff_write_arbiter_rr_pick.sv - combinational round-robin winner search starting at ptr
module rr_pick
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  // Scan from the farthest slot back to ptr so the nearest requester wins last.
  always_comb begin
    winner_o = ptr_i;
    any_o    = |req_i;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N_REQ]) begin
        winner_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - round-robin arbitrated writes into one shared data register
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dff_write_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] pick;
  logic             any_req;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (pick),
    .any_o    (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      q_q      <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      q_q      <= q_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
    end
  end

  // gnt and ack default to zero, so each is a single-cycle registered pulse.
  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    ack_d    = '0;
    q_d      = q_q;
    owner_d  = owner_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          winner_d    = pick;
          gnt_d[pick] = 1'b1;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A withdrawn request aborts without touching data or the pointer.
        if (bus.req[winner_q]) begin
          q_d             = bus.wdata[winner_q*WIDTH +: WIDTH];
          owner_d         = winner_q;
          valid_d         = 1'b1;
          ack_d[winner_q] = 1'b1;
          cnt_d           = cnt_q + CNT_W'(1);
          ptr_d           = IDX_W'((int'(winner_q) + 1) % N_REQ);
          state_d         = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.gnt        = gnt_q;
  assign bus.ack        = ack_q;
  assign bus.Q          = q_q;
  assign bus.owner      = owner_q;
  assign bus.q_valid    = valid_q;
  assign bus.commit_cnt = cnt_q;

endmodule

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (fixed at 4 for this release).
REQ-002 Parameter WIDTH, default 8, width of the shared data register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req  input  N_REQ  per-requester write request, level, held until ack or withdrawn.
REQ-006 wdata  input  N_REQ*WIDTH  per-requester write data; slice i = wdata[i*WIDTH +: WIDTH].
REQ-007 gnt  output  N_REQ  one-hot grant, registered.
REQ-008 ack  output  N_REQ  one-hot, one-cycle write-committed pulse, registered.
REQ-009 Q  output  WIDTH  shared flip-flop register contents.
REQ-010 owner  output  2  index of the requester that last wrote Q.
REQ-011 q_valid  output  1  high once Q has been written at least once since reset.
REQ-012 commit_cnt  output  8  count of committed writes, wraps 255 -> 0.

Function
REQ-013 FSM states: IDLE, GRANT, WRITE; encoding lives in the shared package.
REQ-014 IDLE: if any req bit is high, pick the winner round-robin starting at index ptr, set gnt to the winner's one-hot, go to GRANT; otherwise stay in IDLE with gnt = 0.
REQ-015 GRANT: if req[winner] is still high, load Q <= wdata[winner], set owner <= winner, set q_valid <= 1, pulse ack[winner], increment commit_cnt, clear gnt, set ptr <= (winner+1) mod N_REQ, go to WRITE.
REQ-016 GRANT abort: if req[winner] is low, clear gnt, go to IDLE; Q, owner, q_valid, commit_cnt and ptr stay unchanged, and no ack is issued.
REQ-017 WRITE: clear ack, go to IDLE unconditionally (one-cycle recovery).
REQ-018 Latency: req sampled at edge k gives gnt high after edge k; Q/ack update after edge k+1; ack low after edge k+2.
REQ-019 Throughput: at most one commit per 3 cycles; a requester holding req after its ack is re-arbitrated normally.
REQ-020 gnt and ack are always zero or one-hot, and are never both nonzero in the same cycle.
REQ-021 Data is sampled only in GRANT; wdata changes at any other time have no effect.
REQ-022 ptr update: ptr advances only on commit; after N_REQ consecutive contended commits, every requester has been served once.
REQ-023 Requests arriving in GRANT or WRITE wait until the next IDLE evaluation.

Reset
REQ-024 When reset = 0, asynchronously force: state = IDLE, gnt = 0, ack = 0, Q = 0, owner = 0, q_valid = 0, commit_cnt = 0, ptr = 0.
REQ-025 Reset mid-transaction (in GRANT or WRITE) discards the transaction: no ack and no Q update.
REQ-026 The first arbitration after reset release occurs on the first rising edge with reset = 1.

Structure
REQ-027 Shared package dff_arb_pkg holds the state encoding, N_REQ/WIDTH defaults and the counter width constant.
REQ-028 The round-robin winner selection is a combinational sub-module rr_pick (inputs req and ptr; outputs winner index and any-request flag).
REQ-029 Q is held in a plain register written only on commit; no latches.

Verification
REQ-030 Reset held 0 with req = 4'b1111 -> all outputs 0; after release, gnt = 4'b0001 after the first edge.
REQ-031 Single request: req = 4'b0100, wdata slice 2 = 8'hA5 -> gnt = 4'b0100 for 1 cycle, then Q = 8'hA5, owner = 2, ack = 4'b0100 for 1 cycle, commit_cnt = 1.
REQ-032 Contention: req = 4'b1111 held, distinct data per requester -> grant order 0,1,2,3,0, with commits spaced exactly 3 cycles apart.
REQ-033 Abort: req[1] dropped during GRANT -> no ack, Q unchanged, ptr unchanged; the next grant goes back to requester 1 if it re-requests.
REQ-034 Reset asserted during GRANT with data 8'h3C -> Q = 0, ack never pulses, q_valid = 0.
REQ-035 256 commits from requester 3 -> commit_cnt wraps to 0, and q_valid stays 1.
